// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle controller and its datapath/memory.
// master drives the decoded instruction, flags and memory status; slave is the controller.
interface multicycle_ctrl_if;
  logic       ir_valid;
  logic [1:0] ins_class;
  logic       S;
  logic       und_in;
  logic [3:0] cond;
  logic [3:0] nzcv;
  logic       mem_ready;

  logic       write_pc;
  logic       write_ir;
  logic       write_reg;
  logic       LA;
  logic       LB;
  logic       LC;
  logic       LF;
  logic       mem_req;
  logic       mem_we;
  logic       wb_sel_mem;
  logic       pc_sel_br;
  logic       fault;
  logic [2:0] state;

  modport master (
    output ir_valid, ins_class, S, und_in, cond, nzcv, mem_ready,
    input  write_pc, write_ir, write_reg, LA, LB, LC, LF,
    input  mem_req, mem_we, wb_sel_mem, pc_sel_br, fault, state
  );

  modport slave (
    input  ir_valid, ins_class, S, und_in, cond, nzcv, mem_ready,
    output write_pc, write_ir, write_reg, LA, LB, LC, LF,
    output mem_req, mem_we, wb_sel_mem, pc_sel_br, fault, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: fetch/decode/execute/memory/writeback with
// ARM-style condition evaluation, a memory-wait timeout and a sticky fault state.
//
// state  | meaning
// FETCH  | wait for ir_valid, load IR and PC+4
// DECODE | read operands, latch class/S, evaluate condition
// EXEC   | ALU operation, or branch PC load
// MEM    | data-memory access, bounded by the wait counter
// WB     | register writeback from ALU or memory
// FAULT  | sticky error, only rst leaves
module multicycle_ctrl #(
  parameter int TO_W    = 4,
  parameter bit COND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5,
    S_BAD6   = 3'd6,
    S_BAD7   = 3'd7
  } state_t;

  localparam logic [1:0] CLS_DP  = 2'd0;
  localparam logic [1:0] CLS_LDR = 2'd1;
  localparam logic [1:0] CLS_STR = 2'd2;
  localparam logic [1:0] CLS_B   = 2'd3;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cls;
  logic              r_s;
  logic [TO_W-1:0]   r_wait;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_pass;
  logic w_cond_ok;
  logic w_timeout;

  logic w_write_pc, w_write_ir, w_write_reg;
  logic w_la, w_lb, w_lc, w_lf;
  logic w_mem_req, w_mem_we, w_wb_sel_mem, w_pc_sel_br, w_fault;

  assign w_n = bus.nzcv[3];
  assign w_z = bus.nzcv[2];
  assign w_c = bus.nzcv[1];
  assign w_v = bus.nzcv[0];

  always_comb begin
    w_cond_pass = 1'b0;
    case (bus.cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = !w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = !w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = !w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = !w_v;
      4'b1000: w_cond_pass = w_c && !w_z;
      4'b1001: w_cond_pass = !w_c || w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = !w_z && (w_n == w_v);
      4'b1101: w_cond_pass = w_z || (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  assign w_cond_ok = COND_EN ? w_cond_pass : 1'b1;
  assign w_timeout = (r_wait == {TO_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cls   <= 2'd0;
      r_s     <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= bus.ins_class;
        r_s   <= bus.S;
      end
      // Held at zero outside MEM so every access starts from a clean count
      if (r_state != S_MEM) begin
        r_wait <= '0;
      end else if (!bus.mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_write_pc   = 1'b0;
    w_write_ir   = 1'b0;
    w_write_reg  = 1'b0;
    w_la         = 1'b0;
    w_lb         = 1'b0;
    w_lc         = 1'b0;
    w_lf         = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_wb_sel_mem = 1'b0;
    w_pc_sel_br  = 1'b0;
    w_fault      = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (bus.ir_valid) begin
          w_write_ir = 1'b1;
          w_write_pc = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_la = 1'b1;
        w_lb = 1'b1;
        if (bus.und_in)      w_next = S_FAULT;
        else if (!w_cond_ok) w_next = S_FETCH;
        else                 w_next = S_EXEC;
      end
      S_EXEC: begin
        w_lc = 1'b1;
        w_lf = r_s && (r_cls == CLS_DP);
        case (r_cls)
          CLS_DP:  w_next = S_WB;
          CLS_B: begin
            w_write_pc  = 1'b1;
            w_pc_sel_br = 1'b1;
            w_next      = S_FETCH;
          end
          default: w_next = S_MEM;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_cls == CLS_STR);
        // A completing access beats a simultaneous timeout
        if (bus.mem_ready)  w_next = (r_cls == CLS_LDR) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB: begin
        w_write_reg  = 1'b1;
        w_wb_sel_mem = (r_cls == CLS_LDR);
        w_next       = S_FETCH;
      end
      S_FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_next = S_FAULT;
      end
    endcase

    // Reset silences every enable in the same cycle, before the state register follows
    if (rst) begin
      w_write_pc   = 1'b0;
      w_write_ir   = 1'b0;
      w_write_reg  = 1'b0;
      w_la         = 1'b0;
      w_lb         = 1'b0;
      w_lc         = 1'b0;
      w_lf         = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_wb_sel_mem = 1'b0;
      w_pc_sel_br  = 1'b0;
      w_fault      = 1'b0;
    end
  end

  assign bus.write_pc   = w_write_pc;
  assign bus.write_ir   = w_write_ir;
  assign bus.write_reg  = w_write_reg;
  assign bus.LA         = w_la;
  assign bus.LB         = w_lb;
  assign bus.LC         = w_lc;
  assign bus.LF         = w_lf;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.wb_sel_mem = w_wb_sel_mem;
  assign bus.pc_sel_br  = w_pc_sel_br;
  assign bus.fault      = w_fault;
  assign bus.state      = r_state;

endmodule
